stack_writer: RTL

STACK_WRITER -- requirements
Module: stack_writer

---
 rtl/stack_writer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/stack_writer.sv
// Pushes a 16-bit word (high byte first) and an optional status byte onto a
// page-1 descending stack, one bus write per cycle, then pulses done.
module stack_writer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] value,
  input  logic [7:0]  status,
  input  logic        push_status,
  input  logic [7:0]  sp_in,
  input  logic        sp_load,
  output logic [15:0] addr,
  output logic [7:0]  data_out,
  output logic        rw,
  output logic [7:0]  sp,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    PUSH_H,
    PUSH_L,
    PUSH_P,
    DONE
  } state_t;

  state_t      state;
  logic [15:0] value_q;
  logic [7:0]  status_q;
  logic        push_status_q;

  // NOTE: these capture registers are deliberately left out of reset; they are
  // only read in states that can be reached after a fresh capture.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      value_q       <= value;
      status_q      <= status;
      push_status_q <= push_status;
    end
  end

  // NOTE: all state and outputs use non-blocking assignments so every
  // register sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sp       <= 8'hFF;
      rw       <= 1'b1;
      data_out <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sp_load) sp <= sp_in;
          if (start) begin
            // First write drives the high byte straight from the accepted word.
            state    <= PUSH_H;
            rw       <= 1'b0;
            data_out <= value[15:8];
            busy     <= 1'b1;
            done     <= 1'b0;
          end else begin
            rw       <= 1'b1;
            data_out <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
          end
        end
        PUSH_H: begin
          sp       <= sp - 8'd1;
          state    <= PUSH_L;
          rw       <= 1'b0;
          data_out <= value_q[7:0];
          busy     <= 1'b1;
          done     <= 1'b0;
        end
        PUSH_L: begin
          sp <= sp - 8'd1;
          if (push_status_q) begin
            state    <= PUSH_P;
            rw       <= 1'b0;
            data_out <= status_q;
            busy     <= 1'b1;
            done     <= 1'b0;
          end else begin
            state    <= DONE;
            rw       <= 1'b1;
            data_out <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        PUSH_P: begin
          sp       <= sp - 8'd1;
          state    <= DONE;
          rw       <= 1'b1;
          data_out <= 8'h00;
          busy     <= 1'b0;
          done     <= 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          rw       <= 1'b1;
          data_out <= 8'h00;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          rw       <= 1'b1;
          data_out <= 8'h00;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  assign addr = {8'h01, sp};

endmodule
